// File: rtl/mem_dump.sv
// Sequential RAM readback engine: walks an inclusive, wrapping address range and
// streams each byte over valid/ready. Optional trailing checksum beat: MEM_DUMP_CHECKSUM_EN.
module mem_dump #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
`ifdef MEM_DUMP_CHECKSUM_EN
    S_CKSUM   = 3'd4,
`endif
    S_DONE    = 3'd5
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cur_r;
  logic [ADDR_W-1:0] last_r;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_r;

  function automatic logic [DATA_W-1:0] cksum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] data);
    return acc + data;
  endfunction
`endif

  // Address walk wraps naturally at the top of the RAM.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign STATE = state_r;

  // Dump sequencer with all outputs registered alongside the state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cur_r      <= '0;
      last_r     <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_r    <= '0;
`endif
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      // Abort also blocks a start presented in IDLE; mem_addr keeps its value.
      state_r    <= S_IDLE;
      mem_rd_en  <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cur_r     <= first_addr;
            last_r    <= last_addr;
            mem_addr  <= first_addr;
            mem_rd_en <= 1'b1;
            busy      <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum_r   <= '0;
`endif
            state_r   <= S_ADDR;
          end else begin
            state_r   <= S_IDLE;
          end
        end
        S_ADDR: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          dout       <= mem_q;
          dout_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          cksum_r    <= cksum_add(cksum_r, mem_q);
          dout_last  <= 1'b0;
`else
          dout_last  <= (cur_r == last_r);
`endif
          state_r    <= S_PRESENT;
        end
        S_PRESENT: begin
          if (dout_ready) begin
            if (cur_r != last_r) begin
              cur_r      <= addr_inc(cur_r);
              mem_addr   <= addr_inc(cur_r);
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              state_r    <= S_ADDR;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              // cksum_r already includes the final byte, added in WAIT.
              dout      <= cksum_r;
              dout_last <= 1'b1;
              state_r   <= S_CKSUM;
`else
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              done       <= 1'b1;
              state_r    <= S_DONE;
`endif
            end
          end else begin
            state_r <= S_PRESENT;
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        S_CKSUM: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b1;
            state_r    <= S_DONE;
          end else begin
            state_r <= S_CKSUM;
          end
        end
`endif
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          mem_rd_en <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          done       <= 1'b0;
          busy       <= 1'b0;
          mem_rd_en  <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
